// File: rtl/upower_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// upower_multicycle_ctrl
//
// Multi-cycle main control FSM for the uPower core. It sequences each
// instruction through FETCH, DECODE, EXEC, MEM and write-back states. It
// drives the 6-bit alu_op consumed by alu_control. It also arbitrates the
// single shared memory port between instruction fetch and data access using a
// req/ack handshake. A wait counter turns a missing mem_ack into a sticky
// bus_err trap.
//
// Optional feature macro: UPOWER_RETIRE_CNT_EN
//   When defined, the design adds the CNT_W-bit retired_cnt output. This
//   counter counts instr_done pulses.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   opcode[5:0]  in   primary opcode from the IR, sampled in DECODE
//   alu_zero     in   ALU zero flag, sampled in BRANCH
//   mem_ack      in   memory completes the current request at this edge
//   mem_req      out  memory request, held until acknowledged
//   mem_we       out  1 = store, 0 = read (valid with mem_req)
//   ir_write     out  load the IR
//   pc_inc       out  PC <- PC + 4
//   pc_branch    out  PC <- branch target
//   reg_write    out  register file write enable
//   wb_sel       out  write-back source, 0 = ALU, 1 = memory
//   alu_src_imm  out  ALU B operand, 1 = immediate
//   alu_op[5:0]  out  opcode presented to alu_control
//   instr_done   out  one-cycle pulse on the last cycle of each instruction
//   illegal      out  sticky, unknown opcode seen
//   bus_err      out  sticky, memory timeout
//   retired_cnt  out  retired instruction count (UPOWER_RETIRE_CNT_EN only)
//   state_o[3:0] out  current state encoding, for debug
// -----------------------------------------------------------------------------
module upower_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
`ifdef UPOWER_RETIRE_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             alu_src_imm,
  output logic [5:0]       alu_op,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_err,
`ifdef UPOWER_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd15
  } state_t;

  // The counter value seen in the last permitted request cycle. If no ack
  // arrives on that edge, the FSM takes the bus-error trap.
  localparam logic [9:0] WAIT_LAST = 10'(MEM_TIMEOUT - 1);

  state_t     state_r;
  logic [5:0] op_q;
  logic [9:0] wait_cnt_r;
  logic       illegal_r;
  logic       bus_err_r;

  logic       req_state_s;
  logic       timeout_s;

  // Decode which states own the memory port, and detect the expiring wait.
  always_comb begin
    req_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) ||
                  (state_r == ST_MEM_WR);
    timeout_s   = req_state_s && !mem_ack && (wait_cnt_r == WAIT_LAST);
  end

  // Main sequencer: state, latched opcode, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      op_q       <= 6'd0;
      wait_cnt_r <= 10'd0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      // Every entry into a request state comes from either a non-request
      // state or an acked request. Clearing in those cases therefore
      // restarts the count on every entry.
      if (req_state_s && !mem_ack) begin
        wait_cnt_r <= wait_cnt_r + 10'd1;
      end else begin
        wait_cnt_r <= 10'd0;
      end

      case (state_r)
        ST_FETCH: begin
          if (mem_ack) begin
            state_r <= ST_DECODE;
          end else if (timeout_s) begin
            state_r   <= ST_TRAP;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          op_q <= opcode;
          case (opcode)
            6'd31:                state_r <= ST_EXEC_R;
            6'd14, 6'd15, 6'd28:  state_r <= ST_EXEC_I;
            6'd32, 6'd36:         state_r <= ST_MEM_ADDR;
            6'd19:                state_r <= ST_BRANCH;
            default: begin
              state_r   <= ST_TRAP;
              illegal_r <= 1'b1;
            end
          endcase
        end
        ST_EXEC_R: state_r <= ST_WB_ALU;
        ST_EXEC_I: state_r <= ST_WB_ALU;
        ST_MEM_ADDR: begin
          if (op_q == 6'd32) begin
            state_r <= ST_MEM_RD;
          end else if (op_q == 6'd36) begin
            state_r <= ST_MEM_WR;
          end else begin
            state_r   <= ST_TRAP;
            illegal_r <= 1'b1;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            state_r <= ST_WB_MEM;
          end else if (timeout_s) begin
            state_r   <= ST_TRAP;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_MEM_RD;
          end
        end
        ST_MEM_WR: begin
          if (mem_ack) begin
            state_r <= ST_FETCH;
          end else if (timeout_s) begin
            state_r   <= ST_TRAP;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_MEM_WR;
          end
        end
        ST_WB_ALU: state_r <= ST_FETCH;
        ST_WB_MEM: state_r <= ST_FETCH;
        ST_BRANCH: state_r <= ST_FETCH;
        ST_TRAP:   state_r <= ST_TRAP;
        default:   state_r <= ST_TRAP;
      endcase
    end
  end

  // Output decode from the registered state. The ack-qualified strobes are
  // Mealy by design so a zero-wait memory costs no extra cycle. All commit
  // strobes are held low on a reset edge so an aborted instruction never
  // writes the register file or PC.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 6'd0;
    instr_done  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack && !rst;
        pc_inc   = mem_ack && !rst;
      end
      ST_EXEC_R: alu_op = op_q;
      ST_EXEC_I: begin
        alu_op      = op_q;
        alu_src_imm = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_op      = op_q;
        alu_src_imm = 1'b1;
      end
      ST_MEM_RD: mem_req = 1'b1;
      ST_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ack && !rst;
      end
      ST_WB_ALU: begin
        reg_write  = !rst;
        instr_done = !rst;
      end
      ST_WB_MEM: begin
        reg_write  = !rst;
        wb_sel     = 1'b1;
        instr_done = !rst;
      end
      ST_BRANCH: begin
        alu_op     = op_q;
        pc_branch  = alu_zero && !rst;
        instr_done = !rst;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign illegal = illegal_r;
  assign bus_err = bus_err_r;
  assign state_o = state_r;

`ifdef UPOWER_RETIRE_CNT_EN
  // Retired-instruction counter; wraps naturally on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (instr_done) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end else begin
      retired_cnt <= retired_cnt;
    end
  end
`endif

endmodule
